// File: rtl/rc5_key_session_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rc5_key_session_if                                           |
// | Description : Key-stream, expander, encryptor and S-RAM signal bundle.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface rc5_key_session_if #(
  parameter int B = 16,
  parameter int R = 12
);
  localparam int B_LENGTH = $clog2(B);
  localparam int T_LENGTH = $clog2(2 * (R + 1));

  logic                iKey_valid;
  logic [7:0]          iKey_byte;
  logic                oKey_ready;
  logic                oKey_we;
  logic [B_LENGTH-1:0] oKey_address;
  logic [7:0]          oKey_data;
  logic                oExp_rst;
  logic                iExpDone;
  logic [T_LENGTH-1:0] iExp_S_address;
  logic                iExp_S_we;
  logic                iEnc_req;
  logic [T_LENGTH-1:0] iEnc_S_address;
  logic                oEnc_grant;
  logic [T_LENGTH-1:0] oS_address;
  logic                oS_we;
  logic                iRekey;
  logic                oReady;
  logic                oError;

  modport master (
    output iKey_valid, iKey_byte, iExpDone, iExp_S_address, iExp_S_we,
           iEnc_req, iEnc_S_address, iRekey,
    input  oKey_ready, oKey_we, oKey_address, oKey_data, oExp_rst,
           oEnc_grant, oS_address, oS_we, oReady, oError
  );

  modport slave (
    input  iKey_valid, iKey_byte, iExpDone, iExp_S_address, iExp_S_we,
           iEnc_req, iEnc_S_address, iRekey,
    output oKey_ready, oKey_we, oKey_address, oKey_data, oExp_rst,
           oEnc_grant, oS_address, oS_we, oReady, oError
  );
endinterface
`default_nettype wire

// File: rtl/rc5_key_session_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rc5_key_session_ctrl                                         |
// | Description : Sequences one RC5 key session: key load, expansion, S-RAM    |
// |               hand-over to the encryptor, and rekey arbitration.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rc5_key_session_ctrl #(
  parameter int W       = 32,
  parameter int B       = 16,
  parameter int R       = 12,
  parameter int TIMEOUT = 1024
) (
  input wire               clk,
  input wire               rst,
  rc5_key_session_if.slave bus
);
  localparam int T         = 2 * (R + 1);
  localparam int B_LENGTH  = $clog2(B);
  localparam int T_LENGTH  = $clog2(T);
  localparam int TO_LENGTH = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_LOAD   = 3'd0;
  localparam logic [2:0] S_EXPAND = 3'd1;
  localparam logic [2:0] S_READY  = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_ERROR  = 3'd4;

  if (W < 1 || TIMEOUT < 2) begin : g_param_check
    $error("rc5_key_session_ctrl: W must be >= 1 and TIMEOUT >= 2");
  end

  logic [2:0]           r_state;
  logic [2:0]           w_next;
  logic [B_LENGTH-1:0]  r_count;
  logic [TO_LENGTH-1:0] r_cycles;
  logic                 r_started;
  logic                 r_exp_rst;
  logic                 w_key_hs;
  logic                 w_last_byte;
  logic                 w_enc_owner;

  assign w_key_hs    = bus.iKey_valid && bus.oKey_ready;
  assign w_last_byte = (r_count == B_LENGTH'(B - 1));
  assign w_enc_owner = (r_state == S_READY) || (r_state == S_DRAIN);

  // A done seen in the first EXPAND cycle is left over from the previous session.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_LOAD:   if (w_key_hs && w_last_byte) w_next = S_EXPAND;
      S_EXPAND: begin
        if ((r_cycles != '0) && bus.iExpDone)
          w_next = S_READY;
        else if (r_cycles == TO_LENGTH'(TIMEOUT - 1))
          w_next = S_ERROR;
      end
      S_READY:  if (bus.iRekey) w_next = bus.iEnc_req ? S_DRAIN : S_LOAD;
      S_DRAIN:  if (!bus.iEnc_req) w_next = S_LOAD;
      S_ERROR:  w_next = S_ERROR;
      default:  w_next = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_LOAD;
      r_count   <= '0;
      r_cycles  <= '0;
      r_started <= 1'b0;
      r_exp_rst <= 1'b1;
    end else begin
      r_state   <= w_next;
      r_started <= 1'b1;
      r_exp_rst <= (w_next != S_EXPAND);
      if (w_key_hs)
        r_count <= w_last_byte ? '0 : r_count + B_LENGTH'(1);
      r_cycles  <= (r_state == S_EXPAND) ? r_cycles + TO_LENGTH'(1) : '0;
    end
  end

  assign bus.oKey_ready   = (r_state == S_LOAD) && r_started;
  assign bus.oKey_we      = w_key_hs;
  assign bus.oKey_address = r_count;
  assign bus.oKey_data    = bus.iKey_byte;
  assign bus.oExp_rst     = r_exp_rst;

  // S port: expander writes during EXPAND, encryptor reads while it owns the table.
  assign bus.oS_we      = (r_state == S_EXPAND) && bus.iExp_S_we;
  assign bus.oS_address = (r_state == S_EXPAND) ? bus.iExp_S_address :
                          w_enc_owner           ? bus.iEnc_S_address : '0;
  assign bus.oEnc_grant = w_enc_owner && bus.iEnc_req;
  assign bus.oReady     = (r_state == S_READY);
  assign bus.oError     = (r_state == S_ERROR);
endmodule
`default_nettype wire
